// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter (with helper parametric_mux)
// Purpose  : Round-robin, packet-locked arbiter sharing one valid/ready bus
//            among NUM_INPUTS requesters. Define ARB_TIMEOUT_EN for stall revoke.
// Revision : 1.0 - initial release
// ============================================================================

module parametric_mux #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic [DATA_WIDTH-1:0] i_data [NUM_INPUTS],
    input  logic [SEL_WIDTH-1:0]  i_sel,
    output logic [DATA_WIDTH-1:0] o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (i_sel == SEL_WIDTH'(i)) o_data = i_data[i];
        end
    end
endmodule

module rr_mux_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_INPUTS     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         BUS_IN [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0]         VALID_IN,
    input  logic [NUM_INPUTS-1:0]         LAST_IN,
    output logic [NUM_INPUTS-1:0]         READY_OUT,
    output logic [DATA_WIDTH-1:0]         BUS_OUT,
    output logic                          VALID_OUT,
    output logic                          LAST_OUT,
    input  logic                          READY_IN,
    output logic [$clog2(NUM_INPUTS)-1:0] SEL_OUT,
`ifdef ARB_TIMEOUT_EN
    output logic                          TIMEOUT_OUT,
`endif
    output logic                          GRANT_ACTIVE_OUT
);
    localparam int c_sel_w = $clog2(NUM_INPUTS);

    if (NUM_INPUTS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rr_mux_arbiter: NUM_INPUTS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_sel_w-1:0]   r_sel;
    logic [c_sel_w-1:0]   r_ptr;
    logic [c_sel_w-1:0]   w_hi;
    logic [c_sel_w-1:0]   w_lo;
    logic                 w_found_hi;
    logic [c_sel_w-1:0]   w_next_sel;
    logic [c_sel_w-1:0]   w_ptr_inc;
    logic                 w_grant;
    logic                 w_valid_sel;
    logic                 w_last_sel;
    logic                 w_end_pkt;
    logic [DATA_WIDTH-1:0] w_mux_data;

    // Nearest valid requester at or above the pointer wins; otherwise wrap to the lowest.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_found_hi = 1'b0;
        for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
            if (VALID_IN[j]) begin
                w_lo = c_sel_w'(j);
                if (c_sel_w'(j) >= r_ptr) begin
                    w_hi       = c_sel_w'(j);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_next_sel = w_found_hi ? w_hi : w_lo;
    end

    assign w_ptr_inc = (r_sel == c_sel_w'(NUM_INPUTS - 1)) ? '0 : r_sel + 1'b1;
    // Reset kills the grant combinationally so outputs drop in the reset cycle itself.
    assign w_grant   = (r_state == ST_GRANT) && !RST;

    always_comb begin
        w_valid_sel = 1'b0;
        w_last_sel  = 1'b0;
        READY_OUT   = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (r_sel == c_sel_w'(j)) begin
                w_valid_sel  = VALID_IN[j];
                w_last_sel   = LAST_IN[j];
                READY_OUT[j] = w_grant & READY_IN;
            end
        end
    end

    parametric_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_WIDTH  (c_sel_w)
    ) u_mux (
        .i_data (BUS_IN),
        .i_sel  (r_sel),
        .o_data (w_mux_data)
    );

    assign BUS_OUT          = w_grant ? w_mux_data : '0;
    assign VALID_OUT        = w_grant & w_valid_sel;
    assign LAST_OUT         = w_grant & w_last_sel;
    assign GRANT_ACTIVE_OUT = w_grant;
    assign SEL_OUT          = r_sel;
    assign w_end_pkt        = w_valid_sel & READY_IN & w_last_sel;

`ifdef ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_cnt_w-1:0] r_stall;
    logic               r_timeout;
    assign TIMEOUT_OUT = r_timeout;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
`ifdef ARB_TIMEOUT_EN
            r_stall   <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (|VALID_IN) begin
                        r_sel   <= w_next_sel;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_end_pkt) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_ptr_inc;
`ifdef ARB_TIMEOUT_EN
                        r_stall <= '0;
                    end else if (w_valid_sel) begin
                        r_stall <= '0;
                    end else if (r_stall == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= ST_IDLE;
                        r_ptr     <= w_ptr_inc;
                        r_timeout <= 1'b1;
                        r_stall   <= '0;
                    end else begin
                        r_stall <= r_stall + 1'b1;
`endif
                    end
                end
            endcase
        end
    end
endmodule

`default_nettype wire
